// File: rtl/result_sig_collect.sv
// result_sig_collect: compacts a stream of harness result words into a MISR signature.
// Optional macro RESULT_SIG_SEED_EN adds seed_i; without it the signature starts from all-ones.
`default_nettype none

module result_sig_collect #(
  parameter int           W         = 64,
  parameter logic [W-1:0] POLY      = 64'h000000000000001B,
  parameter int           N_SAMPLES = 1024,
  parameter int           SKIP      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         valid_i,
  input  logic [W-1:0] result_i,
`ifdef RESULT_SIG_SEED_EN
  input  logic [W-1:0] seed_i,
`endif
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] sig_o,
  output logic [20:0]  count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [20:0] N_MAX     = 21'(N_SAMPLES);
  localparam logic [20:0] N_LAST    = 21'(N_SAMPLES - 1);
  localparam logic [7:0]  SKIP_LAST = 8'(SKIP - 1);

  state_t         state;
  logic [7:0]     skip_cnt;
  logic [W-1:0]   seed_val;
  logic [W-1:0]   next_sig;

`ifdef RESULT_SIG_SEED_EN
  assign seed_val = seed_i;
`else
  assign seed_val = '1;
`endif

  // Galois-style MISR step with the incoming word folded in
  always_comb begin
    next_sig = {sig_o[W-2:0], 1'b0} ^ (sig_o[W-1] ? POLY : '0) ^ result_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sig_o    <= '0;
      count_o  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      skip_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            sig_o    <= seed_val;
            count_o  <= '0;
            skip_cnt <= '0;
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
            state    <= (SKIP > 0) ? FILL : ACC;
          end
        end
        FILL: begin
          // pipeline-fill cycles elapse whether or not the harness flags them valid
          skip_cnt <= skip_cnt + 8'd1;
          if (skip_cnt == SKIP_LAST) begin
            state <= ACC;
          end
        end
        ACC: begin
          if (valid_i) begin
            sig_o <= next_sig;
            if (count_o != N_MAX) begin
              count_o <= count_o + 21'd1;
            end
            if (count_o == N_LAST) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy_o && done_o));
  a_count_bound:    assert property (@(posedge clk) disable iff (!rst_n) count_o <= N_MAX);

endmodule

`default_nettype wire

// File: doc/result_sig_collect.md
RESULT_SIG_COLLECT -- requirements
Module: result_sig_collect

Interface
REQ-001 SHALL have parameter W, default 64, meaning the result word width; it matches the uop harness result width.
REQ-002 SHALL have parameter POLY, W bits, default 64'h000000000000001B, meaning the MISR feedback polynomial (taps, x^W implied).
REQ-003 SHALL have parameter N_SAMPLES, default 1024, range 1..2^20, meaning the number of result words compacted per run.
REQ-004 SHALL have parameter SKIP, default 8, range 0..255, meaning the pipeline-fill cycles discarded after start.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-007 SHALL have port start_i, input, 1, a run request, sampled only in IDLE or DONE.
REQ-008 SHALL have port valid_i, input, 1, qualifying result_i; it is tied high when driven by the free-running harness.
REQ-009 SHALL have port result_i, input, W, the XOR-reduced harness result consumed by this stage.
REQ-010 SHALL have port busy_o, output, 1, high in FILL and ACC.
REQ-011 SHALL have port done_o, output, 1, high in DONE.
REQ-012 SHALL have port sig_o, output, W, the MISR signature register.
REQ-013 SHALL have port count_o, output, 21, the number of samples accepted in the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, ACC and DONE, encoded in 2 bits.
REQ-015 SHALL transition IDLE/DONE -> FILL when start_i=1 and SKIP>0, and IDLE/DONE -> ACC when start_i=1 and SKIP=0; the transition also loads sig_o with the seed, count_o with 0 and the skip counter with 0.
REQ-016 SHALL count every FILL cycle regardless of valid_i and go FILL -> ACC after exactly SKIP cycles in FILL.
REQ-017 SHALL, in ACC with valid_i=1, update sig = (sig<<1) ^ (sig[W-1] ? POLY : 0) ^ result_i and increment count_o.
REQ-018 SHALL, in ACC with valid_i=0, hold sig_o and count_o unchanged.
REQ-019 SHALL go ACC -> DONE on the cycle the N_SAMPLES-th sample is accepted; sig_o and done_o are visible the following cycle.
REQ-020 SHALL give latency start_i -> done_o of SKIP + N_SAMPLES + 1 cycles with valid_i held high.
REQ-021 SHALL, in DONE, hold sig_o and count_o stable until the next start_i; start_i in DONE restarts the run directly.
REQ-022 SHALL ignore start_i while busy_o=1, with no restart and no counter perturbation.
REQ-023 SHALL keep busy_o and done_o mutually exclusive and never both high.
REQ-024 SHALL make count_o saturate at N_SAMPLES and never wrap.

Reset
REQ-025 SHALL, on rst_n low, immediately set state=IDLE, sig_o='0, count_o=0, busy_o=0, done_o=0 and the skip counter to 0, regardless of clock.
REQ-026 SHALL abandon a run on reset mid-FILL or mid-ACC with no done_o pulse; after reset release, the block waits for a new start_i.

Configuration
REQ-027 SHALL recognise macro RESULT_SIG_SEED_EN; when defined, it adds input port seed_i (W bits), and the start transition loads sig with seed_i.
REQ-028 SHALL, without RESULT_SIG_SEED_EN, have no seed_i port, and the start transition loads sig with all-ones ('1).

Verification (bench params W=8, POLY=8'h1D, N_SAMPLES=4, SKIP=2)
REQ-029 SHALL cover: macro off, start pulse, valid_i=1, result_i=8'h00 -> done_o rises 7 cycles after start, sig_o=8'h4B, count_o=4.
REQ-030 SHALL cover: macro on, seed_i=8'h00, result_i=8'h01 constant -> sig_o=8'h0F at done_o.
REQ-031 SHALL cover: same as REQ-029 but valid_i low for 3 cycles inside ACC -> done_o delayed by exactly 3 cycles, sig_o still 8'h4B.
REQ-032 SHALL cover: start_i re-pulsed during FILL and during ACC -> ignored, done timing and sig_o unchanged from REQ-029.
REQ-033 SHALL cover: rst_n asserted asynchronously mid-ACC -> outputs zero within the same cycle, no done_o; a subsequent start reproduces 8'h4B.
REQ-034 SHALL cover: SKIP=0, N_SAMPLES=1, result_i=8'hA5, macro off -> done_o 2 cycles after start, sig_o = 8'hE3 ^ 8'hA5 = 8'h46.
